// File: rtl/aes_axis_tx.sv
// aes_axis_tx: drains 128-bit AES result blocks from the output FIFO and
//   serializes each one into AXI4-Stream beats, MSB end first, toward the DMA.
// Latency: FIFO read handshake to first m_axis_tvalid is 1 cycle; one block
//   takes BEATS+2 cycles with m_axis_tready held high.
// Backpressure: m_axis_tready low stalls any beat indefinitely with data, last
//   and strobe held; the FIFO is only read again once the block is fully sent.
//
// Ports:
//   clk, reset               single clock, synchronous active-high reset
//   processing_done          one-cycle end-of-request pulse from the controller
//   out_fifo_*               read side of the output FIFO (empty, valid/ready, data)
//   m_axis_*                 AXI4-Stream master (tdata, tvalid, tready, tlast, tstrb)
//   tx_done                  one-cycle pulse the cycle after the tlast beat is accepted
//   tx_beat_count            (only with AES_AXIS_TX_BEAT_COUNT_EN) accepted beats
//                            of the current request
//
// Optional feature macro: AES_AXIS_TX_BEAT_COUNT_EN.
module aes_axis_tx #(
    parameter int FIFO_DATA_WIDTH = 128,
    parameter int AXIS_DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         processing_done,
    input  logic                         out_fifo_empty,
    input  logic                         out_fifo_read_tvalid,
    output logic                         out_fifo_read_tready,
    input  logic [FIFO_DATA_WIDTH-1:0]   out_fifo_data,
    output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                         tx_done
`ifdef AES_AXIS_TX_BEAT_COUNT_EN
    ,
    output logic [31:0]                  tx_beat_count
`endif
);

    // BEATS must be an integer >= 2 (FIFO width a multiple of the beat width).
    localparam int BEATS = FIFO_DATA_WIDTH / AXIS_DATA_WIDTH;
    localparam int IDX_W = (BEATS > 2) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_SEND   = 2'd1,
        ST_DECIDE = 2'd2,
        ST_LAST   = 2'd3
    } state_t;

    state_t                       r_state;
    logic [FIFO_DATA_WIDTH-1:0]   r_blk;
    logic [IDX_W-1:0]             r_idx;
    logic                         r_done_flag;
    logic                         r_msg_active;
    logic                         r_last;

    // Registered outputs
    logic                         r_rd_rdy;
    logic                         r_tvalid;
    logic                         r_tlast;
    logic [AXIS_DATA_WIDTH-1:0]   r_tdata;
    logic [AXIS_DATA_WIDTH/8-1:0] r_tstrb;
    logic                         r_tx_done;

    state_t                       w_state_nxt;
    logic [FIFO_DATA_WIDTH-1:0]   w_blk_nxt;
    logic [IDX_W-1:0]             w_idx_nxt;
    logic                         w_msg_nxt;
    logic                         w_last_nxt;
    logic                         w_done_clr;
    logic                         w_tx_done_nxt;
    logic                         w_rd_hs;
    logic                         w_m_hs;
    logic                         w_tvalid_nxt;
    logic [AXIS_DATA_WIDTH-1:0]   w_tdata_nxt;

    assign w_rd_hs = r_rd_rdy && out_fifo_read_tvalid;
    assign w_m_hs  = r_tvalid && m_axis_tready;

    always_comb begin
        w_state_nxt   = r_state;
        w_blk_nxt     = r_blk;
        w_idx_nxt     = r_idx;
        w_msg_nxt     = r_msg_active;
        w_last_nxt    = r_last;
        w_done_clr    = 1'b0;
        w_tx_done_nxt = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_rd_hs) begin
                    w_blk_nxt   = out_fifo_data;
                    w_msg_nxt   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_SEND;
                end else if (r_done_flag && out_fifo_empty && !r_msg_active) begin
                    // Request produced no output blocks: swallow the done.
                    w_done_clr = 1'b1;
                end
            end
            ST_SEND: begin
                if (w_m_hs) begin
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == IDX_W'(BEATS - 2)) begin
                        w_state_nxt = ST_DECIDE;
                    end
                end
            end
            ST_DECIDE: begin
                // Final beat is held until we know whether another block follows.
                if (!out_fifo_empty) begin
                    w_last_nxt  = 1'b0;
                    w_state_nxt = ST_LAST;
                end else if (r_done_flag) begin
                    w_last_nxt  = 1'b1;
                    w_state_nxt = ST_LAST;
                end
            end
            ST_LAST: begin
                if (w_m_hs) begin
                    w_state_nxt = ST_FETCH;
                    if (r_last) begin
                        w_done_clr    = 1'b1;
                        w_msg_nxt     = 1'b0;
                        w_tx_done_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = ST_FETCH;
        endcase
    end

    // Output values are derived from the next state so they can be registered
    // without adding latency; beat 0 is the most significant slice.
    always_comb begin
        w_tvalid_nxt = (w_state_nxt == ST_SEND) || (w_state_nxt == ST_LAST);
        w_tdata_nxt  = '0;
        for (int k = 0; k < BEATS; k++) begin
            if (int'(w_idx_nxt) == k) begin
                w_tdata_nxt = w_blk_nxt[(BEATS-1-k)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_FETCH;
            r_blk        <= '0;
            r_idx        <= '0;
            r_done_flag  <= 1'b0;
            r_msg_active <= 1'b0;
            r_last       <= 1'b0;
            r_rd_rdy     <= 1'b0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_tdata      <= '0;
            r_tstrb      <= '0;
            r_tx_done    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_blk        <= w_blk_nxt;
            r_idx        <= w_idx_nxt;
            // A new done pulse wins over a clear in the same cycle.
            r_done_flag  <= processing_done || (r_done_flag && !w_done_clr);
            r_msg_active <= w_msg_nxt;
            r_last       <= w_last_nxt;
            r_rd_rdy     <= (w_state_nxt == ST_FETCH);
            r_tvalid     <= w_tvalid_nxt;
            r_tlast      <= (w_state_nxt == ST_LAST) && w_last_nxt;
            r_tdata      <= w_tdata_nxt;
            r_tstrb      <= w_tvalid_nxt ? '1 : '0;
            r_tx_done    <= w_tx_done_nxt;
        end
    end

    assign out_fifo_read_tready = r_rd_rdy;
    assign m_axis_tvalid        = r_tvalid;
    assign m_axis_tlast         = r_tlast;
    assign m_axis_tdata         = r_tdata;
    assign m_axis_tstrb         = r_tstrb;
    assign tx_done              = r_tx_done;

`ifdef AES_AXIS_TX_BEAT_COUNT_EN
    logic [31:0] r_beat_cnt;

    // Holds the full request count through the tx_done cycle, then clears.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_beat_cnt <= '0;
        end else if (r_tx_done) begin
            r_beat_cnt <= '0;
        end else if (w_m_hs) begin
            r_beat_cnt <= r_beat_cnt + 32'd1;
        end
    end

    assign tx_beat_count = r_beat_cnt;
`endif

endmodule

// File: tb/tb_aes_axis_tx.sv
module tb_aes_axis_tx;

    logic         clk = 1'b0;
    logic         reset;
    logic         processing_done;
    logic         out_fifo_empty;
    logic         out_fifo_read_tvalid;
    logic         out_fifo_read_tready;
    logic [127:0] out_fifo_data;
    logic [31:0]  m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic         m_axis_tlast;
    logic [3:0]   m_axis_tstrb;
    logic         tx_done;
`ifdef AES_AXIS_TX_BEAT_COUNT_EN
    logic [31:0]  tx_beat_count;
    int           bc_model = 0;
`endif

    always #5 clk = ~clk;

    aes_axis_tx #(.FIFO_DATA_WIDTH(128), .AXIS_DATA_WIDTH(32)) dut (
        .clk                  (clk),
        .reset                (reset),
        .processing_done      (processing_done),
        .out_fifo_empty       (out_fifo_empty),
        .out_fifo_read_tvalid (out_fifo_read_tvalid),
        .out_fifo_read_tready (out_fifo_read_tready),
        .out_fifo_data        (out_fifo_data),
        .m_axis_tdata         (m_axis_tdata),
        .m_axis_tvalid        (m_axis_tvalid),
        .m_axis_tready        (m_axis_tready),
        .m_axis_tlast         (m_axis_tlast),
        .m_axis_tstrb         (m_axis_tstrb),
        .tx_done              (tx_done)
`ifdef AES_AXIS_TX_BEAT_COUNT_EN
        ,
        .tx_beat_count        (tx_beat_count)
`endif
    );

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic [127:0] fifo_q[$];
    beat_t        exp_q[$];
    int           beat_cyc[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    int           beats_acc = 0;
    bit           pend_pop = 0;
    bit           prev_stall = 0;
    bit           rand_rdy = 0;
    bit           rst_req = 1;
    bit           pd_req = 0;
    bit           txd_exp = 0;
    logic [31:0]  hold_d = '0;
    logic         hold_l = 1'b0;

    // One clock of stimulus plus monitoring, all done at the falling edge.
    task automatic tick();
        beat_t e;
        bit    acc;
        bit    txd_now;
        @(negedge clk);
        cyc++;
        if (pend_pop && fifo_q.size() > 0) fifo_q.delete(0);
        reset           = rst_req;
        processing_done = pd_req;
        pd_req          = 0;
        out_fifo_read_tvalid = (fifo_q.size() > 0);
        out_fifo_empty       = (fifo_q.size() == 0);
        out_fifo_data        = (fifo_q.size() > 0) ? fifo_q[0] : 128'h0;
        m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        pend_pop = out_fifo_read_tready && out_fifo_read_tvalid && !reset;

        if (prev_stall) begin
            checks++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== hold_d || m_axis_tlast !== hold_l) begin
                errors++;
                $display("FAIL stall_hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                         m_axis_tvalid, m_axis_tdata, m_axis_tlast, hold_d, hold_l);
            end
        end
        checks++;
        if (m_axis_tstrb !== (m_axis_tvalid ? 4'hF : 4'h0)) begin
            errors++;
            $display("FAIL tstrb got %h with tvalid=%b", m_axis_tstrb, m_axis_tvalid);
        end
        checks++;
        if (tx_done !== txd_exp) begin
            errors++;
            $display("FAIL tx_done got %b want %b (cycle %0d)", tx_done, txd_exp, cyc);
        end
`ifdef AES_AXIS_TX_BEAT_COUNT_EN
        checks++;
        if (tx_beat_count !== 32'(bc_model)) begin
            errors++;
            $display("FAIL beat_count got %0d want %0d", tx_beat_count, bc_model);
        end
`endif
        txd_now = txd_exp;
        txd_exp = 0;
        acc = 0;
        if (!reset && m_axis_tvalid === 1'b1 && m_axis_tready) begin
            acc = 1;
            beats_acc++;
            beat_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat got d=%h l=%b want no beat", m_axis_tdata, m_axis_tlast);
            end else begin
                e = exp_q.pop_front();
                if (m_axis_tdata !== e.d || m_axis_tlast !== e.l) begin
                    errors++;
                    $display("FAIL beat got d=%h l=%b want d=%h l=%b", m_axis_tdata, m_axis_tlast, e.d, e.l);
                end
                if (e.l) txd_exp = 1;
            end
        end
`ifdef AES_AXIS_TX_BEAT_COUNT_EN
        if (reset) bc_model = 0;
        else if (txd_now) bc_model = 0;
        else if (acc) bc_model = bc_model + 1;
`endif
        if (reset) txd_exp = 0;
        prev_stall = !reset && (m_axis_tvalid === 1'b1) && !m_axis_tready;
        hold_d = m_axis_tdata;
        hold_l = m_axis_tlast;
    endtask

    task automatic push_block(input logic [127:0] b);
        beat_t e;
        fifo_q.push_back(b);
        for (int k = 0; k < 4; k++) begin
            e.d = b[(3-k)*32 +: 32];
            e.l = 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // The final beat of the request is still queued, so mark it as tlast.
    task automatic request_done();
        beat_t e;
        pd_req = 1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_back();
            e.l = 1'b1;
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int max_cyc, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d beats left want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) tick();
    endtask

    task automatic wait_exp(input int left, input int max_cyc, input string name);
        int n = 0;
        while (exp_q.size() > left && n < max_cyc) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() > left) begin
            errors++;
            $display("FAIL %s_timeout got %0d beats left want %0d", name, exp_q.size(), left);
        end
    endtask

    task automatic test_reset();
        rst_req = 1;
        repeat (3) tick();
        checks++;
        if (out_fifo_read_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
            m_axis_tstrb !== 4'h0 || m_axis_tdata !== 32'h0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b l=%b s=%h d=%h td=%b want all 0",
                     out_fifo_read_tready, m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata, tx_done);
        end
        rst_req = 0;
        tick();
        tick();
        checks++;
        if (out_fifo_read_tready !== 1'b1) begin
            errors++;
            $display("FAIL rdy_after_reset got %b want 1", out_fifo_read_tready);
        end
    endtask

    task automatic test_single_block();
        int b0 = beats_acc;
        push_block(128'h00112233_44556677_8899AABB_CCDDEEFF);
        repeat (3) tick();
        request_done();
        drain(100, "single");
        checks++;
        if (beats_acc - b0 != 4) begin
            errors++;
            $display("FAIL single_count got %0d want 4", beats_acc - b0);
        end
    endtask

    task automatic test_back_to_back();
        beat_cyc.delete();
        push_block(128'h01010101_02020202_03030303_04040404);
        push_block(128'h11111111_12121212_13131313_14141414);
        push_block(128'h21212121_22222222_23232323_24242424);
        request_done();
        drain(200, "b2b");
        checks++;
        if (beat_cyc.size() != 12) begin
            errors++;
            $display("FAIL b2b_count got %0d want 12", beat_cyc.size());
        end else begin
            checks++;
            if (beat_cyc[4] - beat_cyc[0] != 6 || beat_cyc[8] - beat_cyc[4] != 6) begin
                errors++;
                $display("FAIL b2b_rate got %0d,%0d cycles/block want 6,6",
                         beat_cyc[4] - beat_cyc[0], beat_cyc[8] - beat_cyc[4]);
            end
        end
    endtask

    task automatic test_decide_wait();
        int idle = 0;
        push_block(128'hDEADBEEF_CAFEF00D_0BADC0DE_13579BDF);
        wait_exp(1, 100, "decide_pre");
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_axis_tvalid === 1'b0) idle++;
        end
        checks++;
        if (idle != 20) begin
            errors++;
            $display("FAIL decide_hold got %0d idle cycles want 20", idle);
        end
        request_done();
        drain(50, "decide");
    endtask

    task automatic test_no_output();
        int b0 = beats_acc;
        int idle = 0;
        request_done();
        repeat (5) tick();
        checks++;
        if (beats_acc != b0) begin
            errors++;
            $display("FAIL setkey_beats got %0d want 0", beats_acc - b0);
        end
        push_block(128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F);
        wait_exp(1, 100, "setkey_pre");
        for (int i = 0; i < 8; i++) begin
            tick();
            if (m_axis_tvalid === 1'b0) idle++;
        end
        checks++;
        if (idle != 8) begin
            errors++;
            $display("FAIL setkey_stale_done got %0d idle cycles want 8", idle);
        end
        request_done();
        drain(50, "setkey");
    endtask

    task automatic test_random_ready();
        int b0 = beats_acc;
        rand_rdy = 1;
        push_block(128'h10203040_50607080_90A0B0C0_D0E0F001);
        push_block(128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0);
        request_done();
        drain(400, "rand");
        rand_rdy = 0;
        checks++;
        if (beats_acc - b0 != 8) begin
            errors++;
            $display("FAIL rand_count got %0d want 8", beats_acc - b0);
        end
    endtask

    task automatic test_mid_reset();
        int b0 = beats_acc;
        int n = 0;
        int idle = 0;
        push_block(128'hFFEEDDCC_BBAA9988_77665544_33221100);
        request_done();
        while (beats_acc == b0 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (beats_acc == b0) begin
            errors++;
            $display("FAIL midrst_timeout got 0 beats want 1");
        end
        rst_req = 1;
        tick();
        rst_req = 0;
        tick();
        checks++;
        if (out_fifo_read_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
            m_axis_tstrb !== 4'h0 || m_axis_tdata !== 32'h0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs got rdy=%b v=%b l=%b s=%h d=%h td=%b want all 0",
                     out_fifo_read_tready, m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata, tx_done);
        end
        exp_q.delete();
        fifo_q.delete();
        push_block(128'h31415926_53589793_23846264_33832795);
        wait_exp(1, 100, "midrst_pre");
        for (int i = 0; i < 5; i++) begin
            tick();
            if (m_axis_tvalid === 1'b0) idle++;
        end
        checks++;
        if (idle != 5) begin
            errors++;
            $display("FAIL midrst_stale_done got %0d idle cycles want 5", idle);
        end
        request_done();
        drain(50, "midrst");
    endtask

    initial begin
        reset = 1'b1;
        processing_done = 1'b0;
        out_fifo_empty = 1'b1;
        out_fifo_read_tvalid = 1'b0;
        out_fifo_data = '0;
        m_axis_tready = 1'b1;
        test_reset();
        test_single_block();
        test_back_to_back();
        test_decide_wait();
        test_no_output();
        test_random_ready();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
